// File: rtl/alu_ctrl_seq_if.sv
// Instruction handshake, decoded control outputs and ALU status between
// fetch, the sequencer and the datapath.
interface alu_ctrl_seq_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        rf_we;
    logic [31:0] imm;
    logic        ALUimm;
    logic        ALUfn;
    logic        logicfn;
    logic        fnClass;
    logic        zFlag;
    logic        carryFlag;
    logic        signFlag;
    logic        overflowFlag;
    logic [3:0]  flags_q;
    logic        done;
    logic        illegal;

    modport slave (
        input  instr_valid, instr,
        input  zFlag, carryFlag, signFlag, overflowFlag,
        output instr_ready, rs_addr, rt_addr, rd_addr, rf_we, imm,
        output ALUimm, ALUfn, logicfn, fnClass, flags_q, done, illegal
    );

    modport master (
        output instr_valid, instr,
        output zFlag, carryFlag, signFlag, overflowFlag,
        input  instr_ready, rs_addr, rt_addr, rd_addr, rf_we, imm,
        input  ALUimm, ALUfn, logicfn, fnClass, flags_q, done, illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle ALU control sequencer: accepts an instruction, decodes it,
// holds ALU selects through execute, latches flags and strobes writeback.
//
//   state    | meaning
//   S_IDLE   | instr_ready high, waiting for instr_valid
//   S_DECODE | decode captured instr, register controls; pulse illegal
//   S_EXEC   | controls stable; flags sampled at closing edge (adder ops)
//   S_WB     | done pulse, rf_we unless destination is register 0
module alu_ctrl_seq #(
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    alu_ctrl_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_NEG  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000011;
    localparam logic [5:0] OP_XOR  = 6'b000100;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] imm_q, imm_d;
    logic [3:0]  sel_q, sel_d;      // {ALUimm, ALUfn, logicfn, fnClass}
    logic [3:0]  flg_q, flg_d;      // {Z, C, S, V}

    logic [5:0]  opcode;
    logic        dec_legal;
    logic        dec_dest_rt;
    logic [3:0]  dec_sel;
    logic [31:0] dec_imm;

    assign opcode = instr_q[31:26];

    always_comb begin
        dec_legal   = 1'b1;
        dec_dest_rt = 1'b0;
        dec_sel     = 4'b0000;
        case (opcode)
            OP_ADD:  dec_sel = 4'b0000;
            OP_ADDI: begin
                dec_sel     = 4'b1000;
                dec_dest_rt = 1'b1;
            end
            OP_NEG:  dec_sel = 4'b0100;
            OP_AND:  dec_sel = 4'b0001;
            OP_XOR:  dec_sel = 4'b0011;
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_imm = SIGN_EXT ? {{16{instr_q[15]}}, instr_q[15:0]}
                              : {16'h0000, instr_q[15:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            sel_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            sel_q   <= sel_d;
            flg_q   <= flg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        sel_d   = sel_q;
        flg_d   = flg_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rs_d  = instr_q[25:21];
                rt_d  = instr_q[20:16];
                rd_d  = dec_dest_rt ? instr_q[20:16] : instr_q[15:11];
                imm_d = dec_imm;
                // An undefined opcode leaves every ALU select inactive.
                sel_d   = dec_legal ? dec_sel : 4'b0000;
                state_d = dec_legal ? S_EXEC : S_IDLE;
            end
            S_EXEC: begin
                if (!sel_q[0]) begin
                    flg_d = {bus.zFlag, bus.carryFlag, bus.signFlag, bus.overflowFlag};
                end
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.illegal     = (state_q == S_DECODE) && !dec_legal;
    assign bus.done        = (state_q == S_WB);
    assign bus.rf_we       = (state_q == S_WB) && (rd_q != 5'd0);
    assign bus.rs_addr     = rs_q;
    assign bus.rt_addr     = rt_q;
    assign bus.rd_addr     = rd_q;
    assign bus.imm         = imm_q;
    assign bus.ALUimm      = sel_q[3];
    assign bus.ALUfn       = sel_q[2];
    assign bus.logicfn     = sel_q[1];
    assign bus.fnClass     = sel_q[0];
    assign bus.flags_q     = flg_q;

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Multi-cycle control sequencer that drives the ALU's control inputs. Accepts one 32-bit instruction per handshake, decodes it, and holds register-file addresses, sign-extended immediate and ALU selects (ALUimm, ALUfn, logicfn, fnClass) stable through execute. It captures the ALU status flags into an architectural flag register and issues a one-cycle register-file write strobe. It sits between instruction fetch and the datapath, on the control side of the ALU.

## Interface
Parameters:
- SIGN_EXT, 1: 1 = imm[15:0] sign-extended to 32 bits; 0 = zero-extended.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- instr_valid  in  1  fetch side presents instr.
- instr  in  32  opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
- instr_ready  out  1  high only in IDLE.
- rs_addr, rt_addr  out  5 each  register-file read addresses.
- rd_addr  out  5  write address (rd for R-type, rt for ADDI).
- rf_we  out  1  register-file write strobe, one cycle.
- imm  out  32  extended immediate.
- ALUimm, ALUfn, logicfn, fnClass  out  1 each  ALU selects.
- zFlag, carryFlag, signFlag, overflowFlag  in  1 each  ALU status.
- flags_q  out  4  latched {Z,C,S,V}.
- done  out  1  one-cycle pulse at instruction retire.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Decode table (ALUimm, ALUfn, logicfn, fnClass; dest):
  - 000000 ADD: 0,0,x→0,0; rd.
  - 000001 ADDI: 1,0,0,0; rt.
  - 000010 NEG (0−rt): 0,1,0,0; rd.
  - 000011 AND: 0,0,0,1; rd.
  - 000100 XOR: 0,0,1,1; rd.
  - any other opcode: illegal.
- States: IDLE → DECODE → EXEC → WB → IDLE; DECODE → IDLE on illegal.
- IDLE: instr_ready=1. On instr_valid & instr_ready, capture instr and go to DECODE. Otherwise hold.
- DECODE: register the address, imm and control outputs. Illegal opcode: illegal=1 for this cycle, controls forced 0, next state IDLE, flags_q unchanged.
- EXEC: all outputs held. At the closing edge, flags_q ← {zFlag,carryFlag,signFlag,overflowFlag} for adder-class ops (fnClass=0) only. Logic ops leave flags_q unchanged.
- WB: rf_we=1 unless rd_addr==0, where it stays 0 because register 0 is not writable. done=1 regardless. Next state IDLE.
- Outputs rs_addr/rt_addr/rd_addr/imm/ALU selects stay registered from DECODE until the next DECODE; they are not cleared in IDLE.
- Reset values: state IDLE, instr_ready=1 (combinational from IDLE), all addresses 0, imm 0, all selects 0, rf_we 0, done 0, illegal 0, flags_q 4'b0000.

## Timing
- Handshake accepted at edge E0. DECODE occupies cycle 1, EXEC cycle 2, WB cycle 3 (rf_we, done high). instr_ready returns high in cycle 4.
- Throughput: one instruction per 4 cycles. Illegal instructions take 2 cycles and have no EXEC/WB.
- instr_valid is ignored outside IDLE. The fetch side holds instr until accepted.
- The ALU is combinational. Controls are stable for the whole EXEC cycle, so flags are sampled after one full cycle of settling.
- Reset asserted in any state aborts immediately: no rf_we or done for the in-flight instruction, and flags_q clears. The first accept is possible on the first rising edge after reset deasserts.
- flags_q changes only at the EXEC→WB edge, so it is visible during WB.

## Test plan
- Reset then ADD rs=1, rt=2, rd=3 with valid held: instr_ready falls at E0+1, selects 0/0/0/0, rf_we=1 and done=1 exactly in cycle 3, rd_addr=3; instr_ready high in cycle 4.
- ADDI rt=5, imm=16'hFFFF: with SIGN_EXT=1, imm=32'hFFFFFFFF, ALUimm=1, rd_addr=5. With SIGN_EXT=0, imm=32'h0000FFFF.
- NEG with the bench driving zFlag=0, carryFlag=1, signFlag=1, overflowFlag=0 in EXEC → flags_q=4'b0110 in WB. A following XOR with different bench flags leaves flags_q=4'b0110, and fnClass=1, logicfn=1.
- Opcode 6'b111111: illegal pulses in cycle 1, no rf_we/done, instr_ready high in cycle 2, flags_q unchanged.
- AND with rd=0: done=1 in WB, rf_we stays 0 throughout.
- Assert reset during EXEC of ADD: rf_we and done never pulse, flags_q=0, state IDLE. A new ADD then completes normally.
